cpu_mem_host: RTL and testbench



---
 rtl/cpu_mem_host_if.sv | 12 +
 rtl/cpu_mem_host.sv | 156 +++++++++++++++
 tb/tb_cpu_mem_host.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_host_if.sv
// Host byte-stream port of cpu_mem_host: command/data bytes in, response bytes out.
interface cpu_mem_host_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid);
  modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/cpu_mem_host.sv
// Memory side of the A-RISC cpu: 256x16 IRAM and 256x8 DRAM, loaded, run and
// read back through a byte-stream host command port.
module cpu_mem_host #(
  parameter logic [7:0] DONE_CODE = 8'hA5,
  parameter logic [7:0] ERR_CODE  = 8'hEE
) (
  input  logic                 clk,
  input  logic                 rstn,
  cpu_mem_host_if.slave        host,
  output logic                 cpu_start,
  input  logic                 cpu_idle,
  input  logic [7:0]           iram_addr,
  output logic [15:0]          iram_dout,
  input  logic [7:0]           dram_addr,
  input  logic [7:0]           dram_din,
  input  logic                 dram_write,
  output logic [7:0]           dram_dout
);

  typedef enum logic [3:0] {
    S_CMD, S_ADDR, S_CNT, S_LDI_LO, S_LDI_HI, S_LDD,
    S_RUN_START, S_RUN_WAIT, S_RD_REQ, S_RD_OUT, S_RESP
  } state_t;

  typedef enum logic [1:0] {C_LDI, C_LDD, C_RD} cmd_t;

  state_t     state;
  cmd_t       cmd;
  logic [7:0] addr;
  logic [8:0] cnt;
  logic [7:0] lo;
  logic [7:0] resp;
  logic       run_first;

  logic [15:0] iram [256];
  logic [7:0]  dram [256];
  logic [15:0] iram_q;
  logic [7:0]  dram_q;

  logic       cpu_owns, s_hs, m_hs, last;
  logic       iram_we, dram_we;
  logic [7:0] iram_a, dram_a, dram_wd;

  assign cpu_owns     = (state == S_RUN_START) || (state == S_RUN_WAIT);
  assign host.s_ready = rstn && (state inside {S_CMD, S_ADDR, S_CNT, S_LDI_LO, S_LDI_HI, S_LDD});
  assign s_hs         = host.s_valid && host.s_ready;
  assign m_hs         = host.m_valid && host.m_ready;
  assign last         = (cnt == 9'd1);

  assign iram_a  = cpu_owns ? iram_addr : addr;
  assign dram_a  = cpu_owns ? dram_addr : addr;
  assign iram_we = (state == S_LDI_HI) && s_hs;
  assign dram_we = cpu_owns ? dram_write : ((state == S_LDD) && s_hs);
  assign dram_wd = cpu_owns ? dram_din : host.s_data;

  // Read data registered from the current address; writes return old data.
  always_ff @(posedge clk) begin
    if (iram_we) iram[iram_a] <= {host.s_data, lo};
    if (dram_we) dram[dram_a] <= dram_wd;
    iram_q <= iram[iram_a];
    dram_q <= dram[dram_a];
  end

  assign iram_dout = iram_q;
  assign dram_dout = dram_q;

  // During READ_D the byte comes straight from the DRAM read register, which
  // stays stable because the address is held until the handshake.
  assign host.m_data = (state == S_RD_OUT) ? dram_q : resp;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_CMD;
      cmd       <= C_LDI;
      addr      <= 8'd0;
      cnt       <= 9'd0;
      lo        <= 8'd0;
      resp      <= 8'd0;
      run_first <= 1'b0;
      cpu_start <= 1'b0;
      host.m_valid <= 1'b0;
    end else begin
      case (state)
        S_CMD: if (s_hs) begin
          case (host.s_data)
            8'h01: begin cmd <= C_LDI; state <= S_ADDR; end
            8'h02: begin cmd <= C_LDD; state <= S_ADDR; end
            8'h03: begin cpu_start <= 1'b1; state <= S_RUN_START; end
            8'h04: begin cmd <= C_RD; state <= S_ADDR; end
            default: begin
              resp         <= ERR_CODE;
              host.m_valid <= 1'b1;
              state        <= S_RESP;
            end
          endcase
        end
        S_ADDR: if (s_hs) begin
          addr  <= host.s_data;
          state <= S_CNT;
        end
        S_CNT: if (s_hs) begin
          cnt <= (host.s_data == 8'd0) ? 9'd256 : {1'b0, host.s_data};
          case (cmd)
            C_LDI:   state <= S_LDI_LO;
            C_LDD:   state <= S_LDD;
            default: state <= S_RD_REQ;
          endcase
        end
        S_LDI_LO: if (s_hs) begin
          lo    <= host.s_data;
          state <= S_LDI_HI;
        end
        S_LDI_HI: if (s_hs) begin
          addr  <= addr + 8'd1;
          cnt   <= cnt - 9'd1;
          state <= last ? S_CMD : S_LDI_LO;
        end
        S_LDD: if (s_hs) begin
          addr  <= addr + 8'd1;
          cnt   <= cnt - 9'd1;
          state <= last ? S_CMD : S_LDD;
        end
        S_RUN_START: begin
          cpu_start <= 1'b0;
          run_first <= 1'b1;
          state     <= S_RUN_WAIT;
        end
        // The cpu still looks idle on the first cycle after start.
        S_RUN_WAIT: begin
          run_first <= 1'b0;
          if (!run_first && cpu_idle) begin
            resp         <= DONE_CODE;
            host.m_valid <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RD_REQ: begin
          host.m_valid <= 1'b1;
          state        <= S_RD_OUT;
        end
        S_RD_OUT: if (m_hs) begin
          host.m_valid <= 1'b0;
          addr         <= addr + 8'd1;
          cnt          <= cnt - 9'd1;
          state        <= last ? S_CMD : S_RD_REQ;
        end
        S_RESP: if (m_hs) begin
          host.m_valid <= 1'b0;
          state        <= S_CMD;
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_host.sv
// Scoreboard bench for cpu_mem_host: host-side stimulus, a cpu stand-in, and
// array models of both RAMs that predict every response byte.
module tb_cpu_mem_host;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_host_if hif();

  logic        cpu_start, cpu_idle, dram_write;
  logic [7:0]  iram_addr, dram_addr, dram_din, dram_dout;
  logic [15:0] iram_dout;

  cpu_mem_host dut (
    .clk(clk), .rstn(rstn), .host(hif.slave),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle),
    .iram_addr(iram_addr), .iram_dout(iram_dout),
    .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_write(dram_write), .dram_dout(dram_dout)
  );

  int tests = 0;
  int fails = 0;
  int start_hi = 0;
  int runs = 0;
  bit rand_ready = 1'b0;

  logic [7:0]  dmem [256];
  logic [15:0] imem [256];
  logic [7:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    hif.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      hif.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected bytes on each handshake and checks hold-while-stalled.
  initial begin
    logic       pend;
    logic [7:0] pend_d;
    logic [7:0] e;
    pend = 1'b0;
    pend_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn) pend = 1'b0;
      else begin
        if (cpu_start) start_hi++;
        if (pend) begin
          chk("hold_valid", hif.m_valid, 1);
          chk("hold_data", hif.m_data, pend_d);
        end
        if (hif.m_valid && hif.m_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %0h expected none", hif.m_data);
          end else begin
            e = exp_q.pop_front();
            chk("resp_byte", hif.m_data, e);
          end
        end
        pend   = hif.m_valid && !hif.m_ready;
        pend_d = hif.m_data;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit must_ready);
    int n = 0;
    hif.s_data  = b;
    hif.s_valid = 1'b1;
    @(negedge clk);
    if (must_ready) chk("s_ready_high", hif.s_ready, 1);
    while (!hif.s_ready && n < 2000) begin n++; @(negedge clk); end
    if (!hif.s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready stuck 0 for byte %0h", b);
    end
    @(posedge clk); #1;
    hif.s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_m_valid_idle"}, hif.m_valid, 0);
  endtask

  task automatic load_d(input logic [7:0] a, input int n);
    logic [7:0] b;
    send(8'h02, 1); send(a, 1); send(8'(n), 1);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      dmem[8'(a + i)] = b;
      send(b, 1);
    end
  endtask

  task automatic load_i(input logic [7:0] a, input int n);
    logic [15:0] w;
    send(8'h01, 1); send(a, 1); send(8'(n), 1);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      imem[8'(a + i)] = w;
      send(w[7:0], 1);
      send(w[15:8], 1);
    end
  endtask

  task automatic read_d(input logic [7:0] a, input int n, input string name);
    for (int i = 0; i < n; i++) exp_q.push_back(dmem[8'(a + i)]);
    send(8'h04, 1); send(a, 1); send(8'(n), 1);
    wait_drain(name);
  endtask

  task automatic run_cpu();
    int n = 0;
    runs++;
    send(8'h03, 1);
    @(negedge clk);
    while (!cpu_start && n < 20) begin n++; @(negedge clk); end
    chk("start_seen", cpu_start, 1);
    @(posedge clk); #1;
    cpu_idle  = 1'b0;
    iram_addr = 8'h10;
    @(negedge clk);
    chk("start_one_cycle", cpu_start, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("iram_read", iram_dout, imem[iram_addr]);
      iram_addr = (i == 0) ? 8'h11 : 8'(8'h80 + i - 1);
    end
    dram_addr = 8'h05; dram_din = 8'h3C; dram_write = 1'b1;
    @(posedge clk); #1;
    dram_write = 1'b0;
    dmem[8'h05] = 8'h3C;
    dram_addr = 8'hFE;
    @(posedge clk); #1;
    chk("cpu_dram_read", dram_dout, dmem[8'hFE]);
    repeat (12) @(posedge clk);
    #1;
    exp_q.push_back(8'hA5);
    cpu_idle = 1'b1;
    wait_drain("run");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    hif.s_valid = 1'b0; hif.s_data = 8'h00;
    cpu_idle = 1'b1; iram_addr = 8'h00;
    dram_addr = 8'h00; dram_din = 8'h00; dram_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", hif.s_ready, 0);
    chk("rst_m_valid", hif.m_valid, 0);
    chk("rst_m_data", hif.m_data, 0);
    chk("rst_cpu_start", cpu_start, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", hif.s_ready, 1);
    @(posedge clk); #1;

    // Fill all of DRAM (N=0 means 256) so later reads are fully defined.
    load_d(8'h00, 256);

    send(8'h01, 1); send(8'h10, 1); send(8'h02, 1);
    send(8'h81, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 1);
    imem[8'h10] = 16'h0081;
    imem[8'h11] = 16'h0000;
    load_i(8'h80, 4);

    send(8'h02, 1); send(8'hFE, 1); send(8'h03, 1);
    send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
    dmem[8'hFE] = 8'hAA; dmem[8'hFF] = 8'hBB; dmem[8'h00] = 8'hCC;
    read_d(8'hFE, 3, "read_wrap");

    run_cpu();
    read_d(8'h04, 3, "read_cpu_write");

    exp_q.push_back(8'hEE);
    send(8'h7F, 1);
    wait_drain("unknown_op");
    read_d(8'hFE, 2, "after_unknown");

    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      a = 8'($urandom);
      load_d(a, $urandom_range(1, 12));
      read_d(a - 8'd2, $urandom_range(1, 16), "rand_read");
    end
    read_d(8'($urandom), 256, "read_256");

    load_d(8'h40, 4);
    send(8'h02, 1); send(8'h40, 1); send(8'h04, 1);
    a = 8'($urandom); dmem[8'h40] = a; send(a, 1);
    a = 8'($urandom); dmem[8'h41] = a; send(a, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    read_d(8'h40, 4, "read_after_reset");

    rand_ready = 1'b0;
    run_cpu();
    read_d(8'h00, 8, "final_read");

    #1;
    chk("start_pulse_cycles", start_hi, runs);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
